// File: rtl/pred_pkg.sv
// Shared constants and types for the fetch-stage branch predictor.
package pred_pkg;

    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BGTZ = 6'b000111;

    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;

    typedef enum logic {
        IDLE,
        FLUSH
    } flush_state_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, resolution update, flush control and statistics bundle.
interface branch_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 16
);

    logic [ADDR_W-1:0] if_pc;
    logic [31:0]       if_instr;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              pred_hit;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_mispredict;
    logic              flush_req;
    logic              flush_busy;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] mispredict_cnt;

    modport master (
        output if_pc, if_instr,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output flush_req,
        input  pred_taken, pred_target, pred_hit,
        input  flush_busy, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  if_pc, if_instr,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  flush_req,
        output pred_taken, pred_target, pred_hit,
        output flush_busy, branch_cnt, mispredict_cnt
    );

endinterface

// File: rtl/pred_table.sv
// Direct-mapped predictor storage: valid, tag, counter and target per slot.
module pred_table
    import pred_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [CTR_BITS-1:0] rd_ctr,
    output logic [ADDR_W-1:0]   rd_target,
    input  logic [IDX_BITS-1:0] chk_idx,
    output logic                chk_valid,
    output logic [TAG_BITS-1:0] chk_tag,
    output logic [CTR_BITS-1:0] chk_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_valid,
    input  logic [CTR_BITS-1:0] wr_ctr,
    input  logic                wr_fill,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [ADDR_W-1:0]   wr_target
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic                valid_mem  [DEPTH];
    logic [TAG_BITS-1:0] tag_mem    [DEPTH];
    logic [CTR_BITS-1:0] ctr_mem    [DEPTH];
    logic [ADDR_W-1:0]   target_mem [DEPTH];

    assign rd_valid  = valid_mem[rd_idx];
    assign rd_tag    = tag_mem[rd_idx];
    assign rd_ctr    = ctr_mem[rd_idx];
    assign rd_target = target_mem[rd_idx];

    // Second read feeds the update path's hit/counter decision.
    assign chk_valid = valid_mem[chk_idx];
    assign chk_tag   = tag_mem[chk_idx];
    assign chk_ctr   = ctr_mem[chk_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_mem[i]  <= 1'b0;
                tag_mem[i]    <= '0;
                ctr_mem[i]    <= CTR_BITS'(CTR_WNT);
                target_mem[i] <= '0;
            end
        end else if (wr_en) begin
            valid_mem[wr_idx] <= wr_valid;
            ctr_mem[wr_idx]   <= wr_ctr;
            if (wr_fill) begin
                tag_mem[wr_idx]    <= wr_tag;
                target_mem[wr_idx] <= wr_target;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Tagged 2-bit dynamic branch predictor with static fallback and flush engine.
module branch_predictor
    import pred_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int STAT_W   = 16
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bus
);

    localparam int                 DEPTH = 1 << IDX_BITS;
    localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(DEPTH - 1);
    localparam int                 TAG_HI = IDX_BITS + TAG_BITS + 1;

    flush_state_e        state;
    logic [IDX_BITS-1:0] ptr;
    logic                busy;
    logic [STAT_W-1:0]   br_cnt;
    logic [STAT_W-1:0]   mp_cnt;

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [CTR_BITS-1:0] rd_ctr;
    logic [ADDR_W-1:0]   rd_target;

    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0] up_tag;
    logic                chk_valid;
    logic [TAG_BITS-1:0] chk_tag;
    logic [CTR_BITS-1:0] chk_ctr;
    logic                up_hit;
    logic                up_go;
    logic [CTR_BITS-1:0] ctr_next;

    logic                wr_en;
    logic [IDX_BITS-1:0] wr_idx;
    logic                wr_valid;
    logic [CTR_BITS-1:0] wr_ctr;
    logic                wr_fill;
    logic [TAG_BITS-1:0] wr_tag;
    logic [ADDR_W-1:0]   wr_target;

    logic                is_branch;
    logic                hit;
    logic [15:0]         imm;
    logic [ADDR_W-1:0]   static_target;
    logic                unused_bits;

    assign lk_idx = bus.if_pc[IDX_BITS+1:2];
    assign lk_tag = bus.if_pc[TAG_HI:IDX_BITS+2];
    assign up_idx = bus.upd_pc[IDX_BITS+1:2];
    assign up_tag = bus.upd_pc[TAG_HI:IDX_BITS+2];

    assign unused_bits = ^{bus.if_instr[25:16], bus.upd_pc[1:0],
                           bus.upd_pc[ADDR_W-1:TAG_HI+1]};

    pred_table #(
        .ADDR_W   (ADDR_W),
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (lk_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_ctr    (rd_ctr),
        .rd_target (rd_target),
        .chk_idx   (up_idx),
        .chk_valid (chk_valid),
        .chk_tag   (chk_tag),
        .chk_ctr   (chk_ctr),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_valid  (wr_valid),
        .wr_ctr    (wr_ctr),
        .wr_fill   (wr_fill),
        .wr_tag    (wr_tag),
        .wr_target (wr_target)
    );

    always_comb begin
        is_branch = 1'b0;
        unique case (bus.if_instr[31:26])
            OP_BEQ, OP_BNE, OP_BGTZ: is_branch = 1'b1;
            default:                 is_branch = 1'b0;
        endcase
    end

    assign imm = bus.if_instr[15:0];
    assign static_target = bus.if_pc + ADDR_W'(4)
                         + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};

    assign hit = is_branch && rd_valid && (rd_tag == lk_tag)
              && (state == IDLE);

    always_comb begin
        bus.pred_hit    = 1'b0;
        bus.pred_taken  = 1'b0;
        bus.pred_target = '0;
        if (hit) begin
            bus.pred_hit    = 1'b1;
            bus.pred_taken  = rd_ctr[CTR_BITS-1];
            bus.pred_target = rd_ctr[CTR_BITS-1] ? rd_target : '0;
        end else if (is_branch) begin
            bus.pred_taken  = imm[15];
            bus.pred_target = imm[15] ? static_target : '0;
        end
    end

    assign up_hit = chk_valid && (chk_tag == up_tag);
    assign up_go  = bus.upd_valid && (state == IDLE);

    always_comb begin
        ctr_next = bus.upd_taken ? CTR_BITS'(CTR_WT) : CTR_BITS'(CTR_WNT);
        if (up_hit) begin
            if (bus.upd_taken)
                ctr_next = (&chk_ctr) ? chk_ctr : chk_ctr + CTR_BITS'(1);
            else
                ctr_next = (chk_ctr == '0) ? chk_ctr : chk_ctr - CTR_BITS'(1);
        end
    end

    // The flush walker owns the write port whenever it is running.
    always_comb begin
        wr_en     = up_go;
        wr_idx    = up_idx;
        wr_valid  = 1'b1;
        wr_ctr    = ctr_next;
        wr_fill   = bus.upd_taken || !up_hit;
        wr_tag    = up_tag;
        wr_target = bus.upd_target;
        if (state == FLUSH) begin
            wr_en     = 1'b1;
            wr_idx    = ptr;
            wr_valid  = 1'b0;
            wr_ctr    = CTR_BITS'(CTR_WNT);
            wr_fill   = 1'b0;
            wr_tag    = '0;
            wr_target = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            busy   <= 1'b0;
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.flush_req) begin
                        state <= FLUSH;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                FLUSH: begin
                    ptr <= ptr + IDX_BITS'(1);
                    if (ptr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
            if (up_go) begin
                if (br_cnt != '1)
                    br_cnt <= br_cnt + STAT_W'(1);
                if (bus.upd_mispredict && (mp_cnt != '1))
                    mp_cnt <= mp_cnt + STAT_W'(1);
            end
        end
    end

    assign bus.flush_busy     = busy;
    assign bus.branch_cnt     = br_cnt;
    assign bus.mispredict_cnt = mp_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for the branch predictor.
module tb_branch_predictor;

    localparam logic [31:0] BEQ_NEG = 32'h1000FFFE;
    localparam logic [31:0] BEQ_POS = 32'h10000003;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_b;
    int   exp_m;

    branch_predictor_if #(.ADDR_W(32), .STAT_W(16)) bus ();

    branch_predictor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] ins);
        bus.if_pc    = pc;
        bus.if_instr = ins;
        #1;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic mis);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_taken      = taken;
        bus.upd_target     = tgt;
        bus.upd_mispredict = mis;
        tick();
        bus.upd_valid = 1'b0;
        exp_b++;
        if (mis) exp_m++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.if_pc = '0; bus.if_instr = '0;
        bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
        bus.upd_target = '0; bus.upd_mispredict = 1'b0; bus.flush_req = 1'b0;
        exp_b = 0; exp_m = 0;
        #12;
        checks++;
        if ({bus.flush_busy, bus.branch_cnt, bus.mispredict_cnt} !== 33'd0) begin
            errors++;
            $display("FAIL reset_state got %h want 0",
                     {bus.flush_busy, bus.branch_cnt, bus.mispredict_cnt});
        end
        tick();
        rst_n = 1'b1;
        tick();
        lookup(32'h100, BEQ_POS);
        checks++;
        if (bus.pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_empty got %b want 0", bus.pred_hit);
        end
    endtask

    task automatic test_static();
        logic [31:0] pcs  [5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100};
        logic [31:0] ins  [5] = '{BEQ_NEG, BEQ_POS, 32'h1C008000,
                                  32'h14000010, 32'h2000FFFE};
        logic [33:0] want [5] = '{{2'b01, 32'h000000FC}, {2'b00, 32'h0},
                                  {2'b01, 32'hFFFE0104}, {2'b00, 32'h0},
                                  {2'b00, 32'h0}};
        for (int i = 0; i < 5; i++) begin
            lookup(pcs[i], ins[i]);
            checks++;
            if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== want[i]) begin
                errors++;
                $display("FAIL static_%0d got %h want %h", i,
                         {bus.pred_hit, bus.pred_taken, bus.pred_target}, want[i]);
            end
        end
    endtask

    task automatic test_update();
        update(32'h100, 1'b1, 32'hFC, 1'b0);
        lookup(32'h100, BEQ_POS);
        checks++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {2'b11, 32'hFC}) begin
            errors++;
            $display("FAIL upd_alloc got %h want %h",
                     {bus.pred_hit, bus.pred_taken, bus.pred_target}, {2'b11, 32'hFC});
        end
        update(32'h100, 1'b0, 32'h444, 1'b1);
        lookup(32'h100, BEQ_POS);
        checks++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL upd_nt got %h want %h",
                     {bus.pred_hit, bus.pred_taken, bus.pred_target}, {2'b10, 32'h0});
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) update(32'h100, 1'b1, 32'hFC, 1'b0);
        update(32'h100, 1'b0, 32'h444, 1'b0);
        lookup(32'h100, BEQ_POS);
        checks++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {2'b11, 32'hFC}) begin
            errors++;
            $display("FAIL sat_high got %h want %h",
                     {bus.pred_hit, bus.pred_taken, bus.pred_target}, {2'b11, 32'hFC});
        end
        for (int i = 0; i < 4; i++) update(32'h100, 1'b0, 32'h444, 1'b0);
        lookup(32'h100, BEQ_NEG);
        checks++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL sat_low_neg got %h want %h",
                     {bus.pred_hit, bus.pred_taken, bus.pred_target}, {2'b10, 32'h0});
        end
        update(32'h100, 1'b1, 32'h128, 1'b0);
        lookup(32'h100, BEQ_NEG);
        checks++;
        if ({bus.pred_hit, bus.pred_taken} !== 2'b10) begin
            errors++;
            $display("FAIL sat_low got %b want 10", {bus.pred_hit, bus.pred_taken});
        end
        update(32'h100, 1'b1, 32'h128, 1'b0);
        lookup(32'h100, BEQ_POS);
        checks++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {2'b11, 32'h128}) begin
            errors++;
            $display("FAIL sat_recover got %h want %h",
                     {bus.pred_hit, bus.pred_taken, bus.pred_target}, {2'b11, 32'h128});
        end
    endtask

    task automatic test_alias();
        update(32'h200, 1'b0, 32'h444, 1'b0);
        lookup(32'h100, BEQ_NEG);
        checks++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {2'b01, 32'hFC}) begin
            errors++;
            $display("FAIL alias_old got %h want %h",
                     {bus.pred_hit, bus.pred_taken, bus.pred_target}, {2'b01, 32'hFC});
        end
        lookup(32'h200, BEQ_NEG);
        checks++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL alias_new got %h want %h",
                     {bus.pred_hit, bus.pred_taken, bus.pred_target}, {2'b10, 32'h0});
        end
        lookup(32'h200, 32'h2000FFFE);
        checks++;
        if ({bus.pred_hit, bus.pred_taken} !== 2'b00) begin
            errors++;
            $display("FAIL alias_nonbr got %b want 00", {bus.pred_hit, bus.pred_taken});
        end
    endtask

    task automatic test_collision();
        lookup(32'h200, BEQ_POS);
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h200; bus.upd_taken = 1'b1;
        bus.upd_target = 32'h300; bus.upd_mispredict = 1'b1;
        #1;
        checks++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL coll_old got %h want %h",
                     {bus.pred_hit, bus.pred_taken, bus.pred_target}, {2'b10, 32'h0});
        end
        tick();
        bus.upd_valid = 1'b0;
        exp_b++; exp_m++;
        #1;
        checks++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {2'b11, 32'h300}) begin
            errors++;
            $display("FAIL coll_new got %h want %h",
                     {bus.pred_hit, bus.pred_taken, bus.pred_target}, {2'b11, 32'h300});
        end
        checks++;
        if ({bus.branch_cnt, bus.mispredict_cnt} !== {16'(exp_b), 16'(exp_m)}) begin
            errors++;
            $display("FAIL stats_count got %h want %h",
                     {bus.branch_cnt, bus.mispredict_cnt}, {16'(exp_b), 16'(exp_m)});
        end
    endtask

    task automatic test_flush();
        int n;
        bus.flush_req = 1'b1;
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h300; bus.upd_taken = 1'b1;
        bus.upd_target = 32'h55C; bus.upd_mispredict = 1'b0;
        tick();
        bus.flush_req = 1'b0;
        bus.upd_valid = 1'b0;
        exp_b++;
        checks++;
        if ({bus.flush_busy, bus.branch_cnt} !== {1'b1, 16'(exp_b)}) begin
            errors++;
            $display("FAIL flush_start got %h want %h",
                     {bus.flush_busy, bus.branch_cnt}, {1'b1, 16'(exp_b)});
        end
        n = 0;
        while (bus.flush_busy && n < 200) begin
            if (n == 3) begin
                lookup(32'h200, BEQ_POS);
                checks++;
                if (bus.pred_hit !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_lookup got %b want 0", bus.pred_hit);
                end
            end
            if (n == 5) begin
                bus.upd_valid = 1'b1; bus.upd_pc = 32'h600; bus.upd_taken = 1'b1;
                bus.upd_target = 32'h700; bus.upd_mispredict = 1'b1;
            end
            bus.flush_req = (n == 10);
            tick();
            bus.upd_valid = 1'b0;
            bus.flush_req = 1'b0;
            n++;
        end
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL flush_len got %0d want 64", n);
        end
        checks++;
        if ({bus.branch_cnt, bus.mispredict_cnt} !== {16'(exp_b), 16'(exp_m)}) begin
            errors++;
            $display("FAIL flush_stats got %h want %h",
                     {bus.branch_cnt, bus.mispredict_cnt}, {16'(exp_b), 16'(exp_m)});
        end
        for (int i = 0; i < 4; i++) begin
            lookup(32'h100 * (i + 1) + ((i == 3) ? 32'h300 : 32'h0), BEQ_POS);
            checks++;
            if (bus.pred_hit !== 1'b0) begin
                errors++;
                $display("FAIL flush_clear_%0d got %b want 0", i, bus.pred_hit);
            end
        end
    endtask

    task automatic test_stats();
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h400; bus.upd_taken = 1'b1;
        bus.upd_target = 32'h800; bus.upd_mispredict = 1'b1;
        for (int i = 0; i < 65537; i++) tick();
        bus.upd_valid = 1'b0;
        checks++;
        if ({bus.branch_cnt, bus.mispredict_cnt} !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL stats_sat got %h want ffffffff",
                     {bus.branch_cnt, bus.mispredict_cnt});
        end
    endtask

    task automatic test_reset_mid_flush();
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.flush_busy, bus.branch_cnt, bus.mispredict_cnt} !== 33'd0) begin
            errors++;
            $display("FAIL reset_mid_flush got %h want 0",
                     {bus.flush_busy, bus.branch_cnt, bus.mispredict_cnt});
        end
        tick();
        rst_n = 1'b1;
        lookup(32'h400, BEQ_POS);
        checks++;
        if ({bus.pred_hit, bus.flush_busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_after got %b want 00", {bus.pred_hit, bus.flush_busy});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_static();
        test_update();
        test_saturate();
        test_alias();
        test_collision();
        test_flush();
        test_stats();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
